// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the 16-bit CPU.
// Owns the program counter and runs a req/ack handshake with an instruction
// memory that may insert wait states. Stalls freeze the IF/ID register. A
// fetch that completes during a stall is parked in a one-entry skid buffer.
// Taken branches redirect the PC and squash wrong-path instructions. This
// includes a request that is still outstanding: it is drained and its data
// is dropped.
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous active-high reset
//   stall          hazard unit: freeze PC and IF/ID
//   branch_taken   EX stage: redirect fetch this cycle
//   branch_target  redirect address (bit 0 forced to 0)
//   im_req         fetch request to instruction memory
//   im_addr        fetch address, stable while im_req=1 until im_ack
//   im_ack         memory: im_data valid this cycle
//   im_data        fetched instruction
//   ifid_valid     IF/ID holds a real instruction (0 = bubble)
//   ifid_instruc   IF/ID instruction
//   ifid_pc        address of the IF/ID instruction
//   opcode         ifid_instruc[15:12]
//   funct          ifid_instruc[3:0]
//   offset         ifid_instruc[11:0]
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int                PC_STEP  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               im_req,
  output logic [ADDR_W-1:0]  im_addr,
  input  logic               im_ack,
  input  logic [INSTR_W-1:0] im_data,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instruc,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [3:0]         opcode,
  output logic [3:0]         funct,
  output logic [11:0]        offset
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  // Skid buffer. It is only meaningful while state == HOLD, so the state
  // itself marks the buffer as full or empty.
  logic [INSTR_W-1:0]  buf_instr;
  logic [ADDR_W-1:0]   buf_pc;
  logic [ADDR_W-1:0]   target;

  // Instructions are halfword aligned. Bit 0 is masked rather than sliced
  // off so that every bit of the input port stays connected.
  assign target = branch_target & ~ADDR_W'(1);

  // Decode-field slices of the IF/ID instruction.
  assign opcode = ifid_instruc[INSTR_W-1 -: 4];
  assign funct  = ifid_instruc[3:0];
  assign offset = ifid_instruc[11:0];

  // The PC, the memory request, the skid buffer and IF/ID share one state
  // machine. im_req and im_addr are registered. im_addr changes only on
  // the edge that consumes an ack, or while no request is outstanding.
  // This keeps the address stable for the whole handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      im_req       <= 1'b0;
      im_addr      <= RESET_PC;
      buf_instr    <= '0;
      buf_pc       <= '0;
      ifid_valid   <= 1'b0;
      ifid_instruc <= '0;
      ifid_pc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          state  <= FETCH;
          im_req <= 1'b1;
          if (branch_taken) begin
            pc         <= target;
            im_addr    <= target;
            ifid_valid <= 1'b0;
          end else begin
            im_addr <= pc;
          end
        end

        FETCH: begin
          if (branch_taken) begin
            ifid_valid <= 1'b0;
            pc         <= target;
            if (im_ack) begin
              // The returning word is wrong-path and is dropped.
              // Request the target next cycle.
              state   <= FETCH;
              im_req  <= 1'b1;
              im_addr <= target;
            end else begin
              // The request cannot be withdrawn. Keep the old address
              // on the bus until the memory answers.
              // pc already holds the redirect target.
              state  <= DRAIN;
              im_req <= 1'b1;
            end
          end else if (im_ack && !stall) begin
            ifid_instruc <= im_data;
            ifid_pc      <= pc;
            ifid_valid   <= 1'b1;
            pc           <= pc + STEP;
            im_addr      <= pc + STEP;
            im_req       <= 1'b1;
          end else if (im_ack) begin
            // The word arrived while decode is frozen. Park it and
            // issue no new request until the stall lifts.
            buf_instr <= im_data;
            buf_pc    <= pc;
            im_req    <= 1'b0;
            state     <= HOLD;
          end else if (!stall) begin
            // Wait state with decode free to advance: insert a bubble
            // but leave the stale contents in place.
            ifid_valid <= 1'b0;
          end
          // Wait state while stalled: IF/ID is unchanged.
        end

        HOLD: begin
          if (branch_taken) begin
            // The buffered word is wrong-path. Leaving HOLD discards it.
            ifid_valid <= 1'b0;
            pc         <= target;
            im_addr    <= target;
            im_req     <= 1'b1;
            state      <= FETCH;
          end else if (!stall) begin
            ifid_instruc <= buf_instr;
            ifid_pc      <= buf_pc;
            ifid_valid   <= 1'b1;
            pc           <= buf_pc + STEP;
            im_addr      <= buf_pc + STEP;
            im_req       <= 1'b1;
            state        <= FETCH;
          end
        end

        DRAIN: begin
          // Stall does not matter here: IF/ID already holds a bubble
          // and only the abandoned request must complete. pc acts as
          // the saved target, and a newer branch overwrites it.
          if (branch_taken) begin
            pc         <= target;
            ifid_valid <= 1'b0;
          end
          if (im_ack) begin
            state   <= FETCH;
            im_req  <= 1'b1;
            im_addr <= branch_taken ? target : pc;
          end
        end

        default: begin
          state  <= IDLE;
          im_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic        im_req;
  logic [7:0]  im_addr;
  logic        im_ack;
  logic [15:0] im_data;
  logic        ifid_valid;
  logic [15:0] ifid_instruc;
  logic [7:0]  ifid_pc;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [11:0] offset;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .im_req       (im_req),
    .im_addr      (im_addr),
    .im_ack       (im_ack),
    .im_data      (im_data),
    .ifid_valid   (ifid_valid),
    .ifid_instruc (ifid_instruc),
    .ifid_pc      (ifid_pc),
    .opcode       (opcode),
    .funct        (funct),
    .offset       (offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic        ack;
    logic [15:0] data;
    logic        exp_req;
    logic [7:0]  exp_addr;
    logic        exp_v;
    logic [7:0]  exp_pc;
    logic [15:0] exp_ins;
    logic        exp_new;
  } vec_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] ins;
  } sb_t;

  localparam int NV = 29;
  vec_t vecs [NV];
  sb_t  sbq [$];

  int   n_cmp = 0;
  int   n_err = 0;
  logic prev_v = 1'b0;
  logic [7:0] prev_pc = 8'h00;

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] t,
                              input logic a, input logic [15:0] d,
                              input logic er, input logic [7:0] ea,
                              input logic ev, input logic [7:0] ep,
                              input logic [15:0] ei, input logic en);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.ack = a; v.data = d;
    v.exp_req = er; v.exp_addr = ea; v.exp_v = ev; v.exp_pc = ep;
    v.exp_ins = ei; v.exp_new = en;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Retire newly loaded IF/ID instructions against the scoreboard queue.
  task automatic monitor();
    sb_t e;
    if (ifid_valid === 1'b1 && (!prev_v || ifid_pc !== prev_pc)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h instr %h expected none", ifid_pc, ifid_instruc);
      end else begin
        e = sbq.pop_front();
        check("sb_pc", {8'h00, ifid_pc}, {8'h00, e.pc});
        check("sb_instr", ifid_instruc, e.ins);
        $display("retired pc=%h instr=%h", ifid_pc, ifid_instruc);
      end
    end
    prev_v  = ifid_valid;
    prev_pc = ifid_pc;
  endtask

  initial begin
    // Columns: stall br tgt ack data | req addr | valid pc instr new
    // 1: reset release, zero-wait memory
    vecs[0]  = mk(0,0,8'h00,0,16'h0000, 0,8'h00, 0,8'h00,16'h0000,0);
    vecs[1]  = mk(0,0,8'h00,1,16'h1234, 1,8'h00, 1,8'h00,16'h1234,1);
    vecs[2]  = mk(0,0,8'h00,1,16'h5678, 1,8'h02, 1,8'h02,16'h5678,1);
    // 2: two wait states at 04
    vecs[3]  = mk(0,0,8'h00,0,16'hFFFF, 1,8'h04, 0,8'h02,16'h5678,0);
    vecs[4]  = mk(0,0,8'h00,0,16'hFFFF, 1,8'h04, 0,8'h02,16'h5678,0);
    vecs[5]  = mk(0,0,8'h00,1,16'h9ABC, 1,8'h04, 1,8'h04,16'h9ABC,1);
    // 3: stall coincident with ack at 06, three stall cycles
    vecs[6]  = mk(1,0,8'h00,1,16'hABCD, 1,8'h06, 1,8'h04,16'h9ABC,0);
    vecs[7]  = mk(1,0,8'h00,0,16'hFFFF, 0,8'h00, 1,8'h04,16'h9ABC,0);
    vecs[8]  = mk(1,0,8'h00,0,16'hFFFF, 0,8'h00, 1,8'h04,16'h9ABC,0);
    vecs[9]  = mk(0,0,8'h00,0,16'hFFFF, 0,8'h00, 1,8'h06,16'hABCD,1);
    vecs[10] = mk(0,0,8'h00,1,16'h1111, 1,8'h08, 1,8'h08,16'h1111,1);
    // 4: branch to 41 with unacked fetch at 0A
    vecs[11] = mk(0,1,8'h41,0,16'hFFFF, 1,8'h0A, 0,8'h08,16'h1111,0);
    vecs[12] = mk(0,0,8'h00,0,16'hFFFF, 1,8'h0A, 0,8'h08,16'h1111,0);
    vecs[13] = mk(0,0,8'h00,1,16'hDEAD, 1,8'h0A, 0,8'h08,16'h1111,0);
    vecs[14] = mk(0,0,8'h00,1,16'h4040, 1,8'h40, 1,8'h40,16'h4040,1);
    // 5: branch together with stall in HOLD
    vecs[15] = mk(1,0,8'h00,1,16'h4242, 1,8'h42, 1,8'h40,16'h4040,0);
    vecs[16] = mk(1,1,8'h80,0,16'hFFFF, 0,8'h00, 0,8'h40,16'h4040,0);
    vecs[17] = mk(0,0,8'h00,1,16'h8080, 1,8'h80, 1,8'h80,16'h8080,1);
    // branch with ack in FETCH, odd target forced even
    vecs[18] = mk(0,1,8'h23,1,16'hBEEF, 1,8'h82, 0,8'h80,16'h8080,0);
    vecs[19] = mk(0,0,8'h00,1,16'h2222, 1,8'h22, 1,8'h22,16'h2222,1);
    // 6: PC wrap FE -> 00
    vecs[20] = mk(0,1,8'hFE,1,16'hBAD0, 1,8'h24, 0,8'h22,16'h2222,0);
    vecs[21] = mk(0,0,8'h00,1,16'hFEFE, 1,8'hFE, 1,8'hFE,16'hFEFE,1);
    vecs[22] = mk(0,0,8'h00,1,16'h0F0F, 1,8'h00, 1,8'h00,16'h0F0F,1);
    // newer branch in DRAIN replaces the saved target
    vecs[23] = mk(0,1,8'h60,0,16'hFFFF, 1,8'h02, 0,8'h00,16'h0F0F,0);
    vecs[24] = mk(0,1,8'h70,0,16'hFFFF, 1,8'h02, 0,8'h00,16'h0F0F,0);
    vecs[25] = mk(0,0,8'h00,1,16'hDDDD, 1,8'h02, 0,8'h00,16'h0F0F,0);
    vecs[26] = mk(0,0,8'h00,1,16'h7070, 1,8'h70, 1,8'h70,16'h7070,1);
    // wait state while stalled keeps IF/ID valid; then enter DRAIN
    vecs[27] = mk(1,0,8'h00,0,16'hFFFF, 1,8'h72, 1,8'h70,16'h7070,0);
    vecs[28] = mk(0,1,8'h10,0,16'hFFFF, 1,8'h72, 0,8'h70,16'h7070,0);

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    im_ack = 1'b0; im_data = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", {15'd0, im_req}, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    check("rst_instr", ifid_instruc, 16'h0000);
    check("rst_pc", {8'h00, ifid_pc}, 16'h0000);
    check("rst_fields", {opcode, funct, offset[7:0]}, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall; branch_taken = vecs[i].br; branch_target = vecs[i].tgt;
      im_ack = vecs[i].ack; im_data = vecs[i].data;
      check($sformatf("row%0d_req", i), {15'd0, im_req}, {15'd0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("row%0d_addr", i), {8'h00, im_addr}, {8'h00, vecs[i].exp_addr});
      if (vecs[i].exp_new) sbq.push_back({vecs[i].exp_pc, vecs[i].exp_ins});
      @(posedge clk);
      #1;
      check($sformatf("row%0d_valid", i), {15'd0, ifid_valid}, {15'd0, vecs[i].exp_v});
      check($sformatf("row%0d_pc", i), {8'h00, ifid_pc}, {8'h00, vecs[i].exp_pc});
      check($sformatf("row%0d_instr", i), ifid_instruc, vecs[i].exp_ins);
      check($sformatf("row%0d_opcode", i), {12'd0, opcode}, {12'd0, vecs[i].exp_ins[15:12]});
      check($sformatf("row%0d_funct", i), {12'd0, funct}, {12'd0, vecs[i].exp_ins[3:0]});
      check($sformatf("row%0d_offset", i), {4'd0, offset}, {4'd0, vecs[i].exp_ins[11:0]});
      $display("row %0d: req=%b addr=%h valid=%b pc=%h instr=%h", i, im_req, im_addr,
               ifid_valid, ifid_pc, ifid_instruc);
      monitor();
    end

    // Asynchronous reset while DRAIN has a request outstanding.
    stall = 1'b0; branch_taken = 1'b0; im_ack = 1'b0; im_data = 16'hFFFF;
    check("drain_req_before", {15'd0, im_req}, 16'h0001);
    #2 reset = 1'b1;
    #1;
    check("drain_rst_req", {15'd0, im_req}, 16'h0000);
    check("drain_rst_valid", {15'd0, ifid_valid}, 16'h0000);
    check("drain_rst_instr", ifid_instruc, 16'h0000);
    check("drain_rst_opcode", {12'd0, opcode}, 16'h0000);
    @(posedge clk);
    #1 reset = 1'b0;
    prev_v = 1'b0;
    check("restart_idle_req", {15'd0, im_req}, 16'h0000);
    @(posedge clk);
    #1;
    check("restart_req", {15'd0, im_req}, 16'h0001);
    check("restart_addr", {8'h00, im_addr}, 16'h0000);
    im_ack = 1'b1; im_data = 16'h7777;
    sbq.push_back({8'h00, 16'h7777});
    @(posedge clk);
    #1;
    check("restart_valid", {15'd0, ifid_valid}, 16'h0001);
    check("restart_pc", {8'h00, ifid_pc}, 16'h0000);
    check("restart_instr", ifid_instruc, 16'h7777);
    monitor();
    im_ack = 1'b0;
    check("restart_next_addr", {8'h00, im_addr}, 16'h0002);

    check("sb_empty", 16'(sbq.size()), 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
